multicycle_control: RTL and testbench

- Moore/Mealy control FSM that sequences a multicycle LEGv8 datapath: IR, PC, register file, one ALU, ALUOut register, shared instruction/data memory, and the immediate sign-extender.
- Supports LDUR, STUR, CBZ, ADD, SUB, AND, ORR.
- Memory is shared and accessed through a req/ready handshake with variable latency.
- Also counts retired instructions.

---
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control unit for a multicycle LEGv8 datapath. It sequences instruction
// fetch, decode, execute, memory access and write-back over a shared
// req/ready memory. It also counts retired instructions and flags
// unsupported opcodes.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             rt_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_ADDR    = 4'd2,
    S_MEM_RD  = 4'd3,
    S_LD_WB   = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_R_WB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ILLEGAL = 4'd9
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic             illegal_reg;
  logic             retire;
  logic             is_ldur, is_stur, is_cbz, is_rtype;

  // Opcode classification; only consulted in DECODE and ADDR.
  always_comb begin
    is_ldur  = 1'b0;
    is_stur  = 1'b0;
    is_cbz   = 1'b0;
    is_rtype = 1'b0;
    casez (opcode)
      11'b11111000010: is_ldur  = 1'b1;
      11'b11111000000: is_stur  = 1'b1;
      11'b10110100???: is_cbz   = 1'b1;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: is_rtype = 1'b1;
      default: ;
    endcase
  end

  // State, retired count and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      count_reg   <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (retire)
        count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      if (state_next == S_ILLEGAL)
        illegal_reg <= 1'b1;
    end
  end

  // Next-state selection; memory states wait for mem_ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (is_ldur || is_stur) state_next = S_ADDR;
        else if (is_rtype)      state_next = S_EXEC_R;
        else if (is_cbz)        state_next = S_BRANCH;
        else                    state_next = S_ILLEGAL;
      end
      S_ADDR:   state_next = is_ldur ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_next = S_LD_WB;
      S_LD_WB:  state_next = S_FETCH;
      S_MEM_WR: if (mem_ready) state_next = S_FETCH;
      S_EXEC_R: state_next = S_R_WB;
      S_R_WB:   state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_ILLEGAL: state_next = S_ILLEGAL;
      default:  state_next = S_FETCH;
    endcase
  end

  // Control strobes per state. The final state of each instruction
  // writes the PC and retires. Reset forces every strobe low so that an
  // in-flight memory request is dropped in the reset cycle itself.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b10;
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_LD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b01;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          retire    = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        pc_write  = 1'b1;
        pc_src    = rt_zero;
        alu_src_b = 2'b01;
        retire    = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      retire     = 1'b0;
    end
  end

  assign illegal     = illegal_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control. A reference model
// describes each instruction as a list of steps. It predicts the strobes,
// the illegal flag and the retire count for every cycle.
module tb_multicycle_control;

  localparam int CW = 4;
  localparam int K_LD = 0, K_ST = 1, K_CB = 2, K_R = 3, K_ILL = 4;

  logic          clk = 1'b0;
  logic          reset, rt_zero, mem_ready;
  logic [10:0]   opcode;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic          reg_write, mem_to_reg, alu_src_a, illegal;
  logic [1:0]    alu_src_b, alu_op;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit chk_en = 1'b0;

  // model state: step index inside the current instruction, its kind,
  // retire count and sticky illegal flag
  int            m_idx  = 0;
  int            m_kind = K_R;
  logic [CW-1:0] m_cnt  = '0;
  logic          m_ill  = 1'b0;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rt_zero(rt_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic int decode(input logic [10:0] op);
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if (op[10:3] == 8'b10110100) return K_CB;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return K_R;
    return K_ILL;
  endfunction

  // index of the final step of each instruction kind
  function automatic int last_idx(input int kind);
    case (kind)
      K_LD:    return 4;
      K_ST:    return 3;
      K_R:     return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit mem_step(input int kind, input int idx);
    return (idx == 0) || (idx == 3 && (kind == K_LD || kind == K_ST));
  endfunction

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
  //  mem_to_reg, alu_src_a, alu_src_b, alu_op}
  function automatic logic [12:0] exp_ctrl(input int kind, input int idx,
                                           input logic mr, input logic rz,
                                           input logic rst);
    logic req, we, ad, irw, pcw, psrc, rw, m2r, a;
    logic [1:0] b, op;
    bit inc;
    req = 0; we = 0; ad = 0; irw = 0; pcw = 0; psrc = 0; rw = 0; m2r = 0;
    a = 0; b = 2'b00; op = 2'b00; inc = 0;
    if (idx == 0) begin
      req = 1; irw = mr;
    end else if (idx == 1) begin
      b = 2'b10;
    end else begin
      case (kind)
        K_LD: case (idx)
          2: begin a = 1; b = 2'b10; end
          3: begin req = 1; ad = 1; end
          default: begin rw = 1; m2r = 1; inc = 1; end
        endcase
        K_ST: case (idx)
          2: begin a = 1; b = 2'b10; end
          default: begin req = 1; we = 1; ad = 1; inc = mr; end
        endcase
        K_R: case (idx)
          2: begin a = 1; op = 2'b10; end
          default: begin rw = 1; inc = 1; end
        endcase
        K_CB: begin pcw = 1; psrc = rz; b = 2'b01; end
        default: ;
      endcase
    end
    if (inc) begin
      pcw = 1; psrc = 0; a = 0; b = 2'b01; op = 2'b00;
    end
    if (rst) return '0;
    return {req, we, ad, irw, pcw, psrc, rw, m2r, a, b, op};
  endfunction

  // reference model advance
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (reset) begin
      m_idx <= 0;
      m_cnt <= '0;
      m_ill <= 1'b0;
    end else if (m_idx == 1) begin
      m_kind <= decode(opcode);
      m_ill  <= m_ill | (decode(opcode) == K_ILL);
      m_idx  <= 2;
    end else if (m_idx >= 2 && m_kind == K_ILL) begin
      m_idx <= m_idx;
    end else if (mem_step(m_kind, m_idx) && !mem_ready) begin
      m_idx <= m_idx;
    end else if (m_idx >= 2 && m_idx == last_idx(m_kind)) begin
      m_idx <= 0;
      m_cnt <= m_cnt + 1'b1;
    end else begin
      m_idx <= m_idx + 1;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic [12:0] got, want;
    if (chk_en) begin
      got  = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
              mem_to_reg, alu_src_a, alu_src_b, alu_op};
      want = exp_ctrl(m_kind, m_idx, mem_ready, rt_zero, reset);
      checks = checks + 1;
      if (got !== want || illegal !== m_ill || instr_count !== m_cnt) begin
        errors = errors + 1;
        $display("FAIL model cycle %0d: ctrl=%b ill=%b cnt=%0d required ctrl=%b ill=%b cnt=%0d (step %0d kind %0d)",
                 cycle, got, illegal, instr_count, want, m_ill, m_cnt, m_idx, m_kind);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end else begin
      $display("check %s ok: %0h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [10:0] rtypes [4];
  int r;

  initial begin
    rtypes[0] = 11'b10001011000;
    rtypes[1] = 11'b11001011000;
    rtypes[2] = 11'b10001010000;
    rtypes[3] = 11'b10101010000;
    reset = 1'b1; mem_ready = 1'b0; rt_zero = 1'b0; opcode = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // ADD with zero-wait memory: 4 cycles, write-back in cycle 4
    opcode = 11'b10001011000; mem_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) lit("reset_count", instr_count, 0);
      if (c == 4) begin
        lit("add_reg_write_c4", reg_write, 1);
        lit("add_pc_inc_c4", {pc_write, pc_src}, 2'b10);
      end else begin
        lit("add_no_reg_write", reg_write, 0);
      end
      tick();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    lit("add_retired", instr_count, 1);

    // unsupported opcode parks in ILLEGAL
    opcode = 11'b00000000000; mem_ready = 1'b1;
    repeat (22) tick();
    @(negedge clk);
    lit("illegal_flag", illegal, 1);
    lit("illegal_strobes", {mem_req, pc_write, reg_write, ir_write}, 0);
    lit("illegal_no_retire", instr_count, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    lit("illegal_cleared", illegal, 0);
    lit("refetch_req", mem_req, 1);

    // STUR aborted by reset while waiting in MEM_WR
    opcode = 11'b11111000000; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    lit("stur_wait_we", {mem_req, mem_we, iord}, 3'b111);
    tick();
    reset = 1'b1;
    @(negedge clk);
    lit("reset_drops_req", mem_req, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    lit("after_abort_count", instr_count, 0);
    lit("after_abort_fetch", mem_req, 1);

    // randomized traffic; count wraps many times at this width
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset     = (m_ill && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
      mem_ready = $urandom_range(0, 1);
      rt_zero   = $urandom_range(0, 1);
      if (m_idx == 0) begin
        r = $urandom_range(0, 19);
        if (r < 4)       opcode = 11'b11111000010;
        else if (r < 8)  opcode = 11'b11111000000;
        else if (r < 12) opcode = {8'b10110100, 3'($urandom_range(0, 7))};
        else if (r < 19) opcode = rtypes[$urandom_range(0, 3)];
        else             opcode = 11'($urandom);
      end
    end
    tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
